ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M/RV64M execute unit alongside the ALU in EX; implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Iterative shift-add multiply and restoring divide, parametrised in operand width and bits retired per cycle. Holds the pipeline through `busy` while working. A one-entry operand cache returns the paired result (DIV→REM, MULH→MUL) without recomputation.

---
 rtl/muldiv_pkg.sv | 69 ++++++
 rtl/muldiv_step.sv | 44 ++++
 rtl/ex_muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings for the RV32M/RV64M multiply/divide unit:
//               funct3 opcodes, FSM states, operand-cache classes and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Signedness class of a cached result; the three multiply flavours are
    // kept apart because their high halves differ.
    typedef enum logic [2:0] {
        CLS_DIV_S  = 3'd0,
        CLS_DIV_U  = 3'd1,
        CLS_MUL_SS = 3'd2,
        CLS_MUL_SU = 3'd3,
        CLS_MUL_UU = 3'd4
    } cls_t;

    // clog2(xlen/bpc + 1): width of the iteration counter
    function automatic int cnt_width(input int xlen, input int bpc);
        int n;
        int w;
        n = xlen / bpc + 1;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    // MUL is computed signed x signed so that a following MULH can hit.
    function automatic cls_t op_class(input logic [2:0] op);
        cls_t c;
        case (op)
            OP_MUL, OP_MULH:  c = CLS_MUL_SS;
            OP_MULHSU:        c = CLS_MUL_SU;
            OP_MULHU:         c = CLS_MUL_UU;
            OP_DIV, OP_REM:   c = CLS_DIV_S;
            OP_DIVU, OP_REMU: c = CLS_DIV_U;
            default:          c = CLS_DIV_U;
        endcase
        return c;
    endfunction

    // High half for MULH*/REM*, low half for MUL/DIV*
    function automatic logic op_sel_hi(input logic [2:0] op);
        return op[2] ? op[1] : (op[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational radix-2 step over the 2*XLEN accumulator.
//               Multiply: add-or-skip into the high half, shift right.
//               Divide  : shift left, trial-subtract, set quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [XLEN-1:0]   opb,
    input  logic [2*XLEN-1:0] acc_in,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;

    // Single radix-2 iteration of either algorithm
    always_comb begin
        w_sum   = '0;
        w_trial = '0;
        w_diff  = '0;
        acc_out = acc_in;
        if (is_div) begin
            // partial remainder shifted left with the next dividend bit
            w_trial = acc_in[2*XLEN-1:XLEN-1];
            w_diff  = w_trial - {1'b0, opb};
            if (!w_diff[XLEN]) begin
                acc_out = {w_diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {w_trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            w_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opb} : '0);
            acc_out = {w_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide execute unit with a
//               one-entry operand cache returning the paired result.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_adr_in,
    input  logic            kill,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_adr_out
);

    import muldiv_pkg::*;

    localparam int            CW      = cnt_width(XLEN, BPC);
    localparam logic [CW-1:0] C_ITER  = CW'(XLEN / BPC);
    localparam logic [CW-1:0] C_LAST  = CW'(2);
    localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_rs1;
    logic [XLEN-1:0]     r_rs2;
    logic [XLEN-1:0]     r_opb;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd;

    logic                r_c_valid;
    cls_t                r_c_cls;
    logic [XLEN-1:0]     r_c_rs1;
    logic [XLEN-1:0]     r_c_rs2;
    logic [XLEN-1:0]     r_c_hi;
    logic [XLEN-1:0]     r_c_lo;

    // ---------------- issue / cache lookup ----------------
    logic            w_accept;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_val;

    assign w_accept  = (r_state == ST_IDLE) & start & ~stall & ~kill;
    assign w_hit     = r_c_valid & (r_c_rs1 == rs1) & (r_c_rs2 == rs2) & (r_c_cls == op_class(op));
    assign w_hit_val = op_sel_hi(op) ? r_c_hi : r_c_lo;

    // ---------------- operand preparation ----------------
    logic            w_s1;
    logic            w_s2;
    logic            w_n1;
    logic            w_n2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_is_div;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_val;

    assign w_s1     = (r_op == OP_MUL) | (r_op == OP_MULH) | (r_op == OP_MULHSU) |
                      (r_op == OP_DIV) | (r_op == OP_REM);
    assign w_s2     = (r_op == OP_MUL) | (r_op == OP_MULH) |
                      (r_op == OP_DIV) | (r_op == OP_REM);
    assign w_n1     = w_s1 & r_rs1[XLEN-1];
    assign w_n2     = w_s2 & r_rs2[XLEN-1];
    assign w_abs1   = w_n1 ? -r_rs1 : r_rs1;
    assign w_abs2   = w_n2 ? -r_rs2 : r_rs2;
    assign w_is_div = r_op[2];
    assign w_div0   = w_is_div & (r_rs2 == '0);
    assign w_ovf    = w_is_div & ~r_op[0] & (r_rs1 == C_MOST_NEG) & (&r_rs2);
    // r_op[1] distinguishes REM* from DIV*
    assign w_special_val = w_div0 ? (r_op[1] ? r_rs1 : '1)
                                  : (r_op[1] ? '0    : r_rs1);

    // ---------------- step chain ----------------
    // PREP already retires the first group straight from the absolute
    // values, so CALC only needs XLEN/BPC-1 cycles.
    logic [2*XLEN-1:0] w_chain [BPC+1];
    logic [XLEN-1:0]   w_opb;

    assign w_chain[0] = (r_state == ST_PREP) ? {{XLEN{1'b0}}, w_abs1} : r_acc;
    assign w_opb      = (r_state == ST_PREP) ? w_abs2 : r_opb;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_chain
            muldiv_step #(
                .XLEN    (XLEN)
            ) u_step (
                .is_div  (w_is_div),
                .opb     (w_opb),
                .acc_in  (w_chain[gi]),
                .acc_out (w_chain[gi+1])
            );
        end
    endgenerate

    // ---------------- sign fix-up ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_hi;
    logic [XLEN-1:0]   w_fix_lo;
    logic [XLEN-1:0]   w_fix_val;

    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_quo     = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem     = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_hi  = w_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
    assign w_fix_lo  = w_is_div ? w_quo : w_prod[XLEN-1:0];
    assign w_fix_val = op_sel_hi(r_op) ? w_fix_hi : w_fix_lo;

    // Control FSM, datapath registers and operand cache
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_rd      <= '0;
            r_c_valid <= 1'b0;
            r_c_cls   <= CLS_DIV_S;
            r_c_rs1   <= '0;
            r_c_rs2   <= '0;
            r_c_hi    <= '0;
            r_c_lo    <= '0;
        end else if (kill) begin
            r_state   <= ST_IDLE;
            r_c_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stall) begin
                        r_op  <= op;
                        r_rs1 <= rs1;
                        r_rs2 <= rs2;
                        r_rd  <= rd_adr_in;
                        if (w_hit) begin
                            r_result <= w_hit_val;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    // product sign, quotient sign and remainder sign share
                    // the same operand-sign terms
                    r_neg_q <= w_n1 ^ w_n2;
                    r_neg_r <= w_n1;
                    r_opb   <= w_abs2;
                    if (w_div0 || w_ovf) begin
                        r_result <= w_special_val;
                        r_state  <= ST_DONE;
                    end else begin
                        r_acc   <= w_chain[BPC];
                        r_cnt   <= C_ITER;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_chain[BPC];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == C_LAST) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_result  <= w_fix_val;
                    r_c_valid <= 1'b1;
                    r_c_cls   <= op_class(r_op);
                    r_c_rs1   <= r_rs1;
                    r_c_rs2   <= r_rs2;
                    r_c_hi    <= w_fix_hi;
                    r_c_lo    <= w_fix_lo;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (!stall) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // done/busy react to stall and kill in the same cycle, so they are
    // decoded from the registered state rather than registered themselves.
    assign done       = (r_state == ST_DONE) & ~stall & ~kill;
    assign busy       = ((r_state != ST_IDLE) & ~((r_state == ST_DONE) & ~stall)) | w_accept;
    assign result     = r_result;
    assign rd_adr_out = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit (XLEN=32, BPC=4)
//               against a plain-arithmetic reference model with cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam int BPC  = 4;
    localparam int LAT_FULL = XLEN / BPC + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_adr_in;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_adr_out;

    int total = 0;
    int bad   = 0;

    // reference cache state
    bit          m_valid = 0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cls;

    ex_muldiv_unit #(
        .XLEN       (XLEN),
        .BPC        (BPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd_adr_in  (rd_adr_in),
        .kill       (kill),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_adr_out (rd_adr_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int cls_of(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return 2;   // MUL pairs with MULH (signed x signed)
            3'd2:       return 3;
            3'd3:       return 4;
            3'd4, 3'd6: return 0;
            default:    return 1;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ps;
        logic [63:0] pu;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // expected latency; updates the reference cache like a completed op
    task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        if (m_valid && m_a == a && m_b == b && m_cls == cls_of(o)) begin
            lat = 1;
        end else if (is_special(o, a, b)) begin
            lat = 2;
        end else begin
            lat     = LAT_FULL;
            m_valid = 1;
            m_a     = a;
            m_b     = b;
            m_cls   = cls_of(o);
        end
    endtask

    // drive one instruction from IDLE and collect its outcome; returns to IDLE
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo, output int lat,
                         output logic busy_acc, output logic busy_done);
        op = o; rs1 = a; rs2 = b; rd_adr_in = rd; start = 1'b1;
        #1 busy_acc = busy;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res       = result;
        rdo       = rd_adr_out;
        busy_done = busy;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; stall = 1'b0;
        op = '0; rs1 = '0; rs2 = '0; rd_adr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, result, rd_adr_out} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h rd=%0d, required all zero",
                     busy, done, result, rd_adr_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        int          lat;
    } plan_t;

    task automatic test_plan();
        plan_t       p [8];
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          mlat;
        logic        ba;
        logic        bd;
        p[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_FULL};
        p[1] = '{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1};
        p[2] = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT_FULL};
        p[3] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1};
        p[4] = '{3'd7, 32'hFFFF_FFF9,  32'd2,         32'd1,         LAT_FULL};
        p[5] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        p[6] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
        p[7] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL};
        for (int i = 0; i < 8; i++) begin
            model_issue(p[i].o, p[i].a, p[i].b, mlat);
            issue(p[i].o, p[i].a, p[i].b, 5'(i + 1), res, rdo, lat, ba, bd);
            total++;
            if (res !== p[i].want || res !== ref_result(p[i].o, p[i].a, p[i].b)) begin
                bad++;
                $display("FAIL plan_result[%0d]: got %h, required %h", i, res, p[i].want);
            end
            total++;
            if (lat != p[i].lat || lat != mlat) begin
                bad++;
                $display("FAIL plan_latency[%0d]: got %0d, required %0d", i, lat, p[i].lat);
            end
            total++;
            if (rdo !== 5'(i + 1) || ba !== 1'b1 || bd !== 1'b0) begin
                bad++;
                $display("FAIL plan_handshake[%0d]: rd=%0d busy_acc=%b busy_done=%b, required rd=%0d 1 0",
                         i, rdo, ba, bd, i + 1);
            end
        end
        // MULHSU -1 x 0xFFFFFFFF
        model_issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mlat);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, ba, bd);
        total++;
        if (res !== 32'hFFFF_FFFF || lat != mlat) begin
            bad++;
            $display("FAIL plan_mulhsu: got %h lat %0d, required ffffffff lat %0d", res, lat, mlat);
        end
    endtask

    task automatic test_kill();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          mlat;
        logic        ba;
        logic        bd;
        bit          seen;
        a = 32'd1234567;
        b = 32'd89;
        model_issue(3'd0, a, b, mlat);
        issue(3'd0, a, b, 5'd3, res, rdo, lat, ba, bd);
        // DIV with the same operands, killed in CALC cycle 5
        op = 3'd4; rs1 = a; rs2 = b; rd_adr_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        kill = 1'b1;
        #1 if (done) seen = 1;
        @(posedge clk); #1;
        kill = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL kill_to_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        repeat (LAT_FULL) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL kill_no_done: done observed=1, required 0");
        end
        m_valid = 0;
        // the earlier MUL must no longer hit, nor the killed DIV
        model_issue(3'd1, a, b, mlat);
        issue(3'd1, a, b, 5'd5, res, rdo, lat, ba, bd);
        total++;
        if (lat != mlat || res !== ref_result(3'd1, a, b)) begin
            bad++;
            $display("FAIL kill_invalidates: lat %0d res %h, required lat %0d res %h",
                     lat, res, mlat, ref_result(3'd1, a, b));
        end
        model_issue(3'd4, a, b, mlat);
        issue(3'd4, a, b, 5'd6, res, rdo, lat, ba, bd);
        total++;
        if (lat != mlat || res !== ref_result(3'd4, a, b)) begin
            bad++;
            $display("FAIL kill_reissue: lat %0d res %h, required lat %0d res %h",
                     lat, res, mlat, ref_result(3'd4, a, b));
        end
        // start together with kill is ignored
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
        #1 seen = busy;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        total++;
        if (seen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL kill_with_start: busy_acc=%b busy=%b done=%b, required 0 0 0", seen, busy, done);
        end
        m_valid = 0;
    endtask

    task automatic test_stall();
        logic [31:0] want;
        logic [31:0] r0;
        logic [4:0]  rd0;
        int          mlat;
        int          lat;
        bit          early;
        want = ref_result(3'd5, 32'd1000, 32'd7);
        model_issue(3'd5, 32'd1000, 32'd7, mlat);
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; rd_adr_in = 5'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b1;
        lat   = 1;
        early = 0;
        while (lat < mlat) begin
            if (done) early = 1;
            @(posedge clk); #1;
            lat++;
        end
        r0  = result;
        rd0 = rd_adr_out;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b1 || result !== r0 || rd_adr_out !== rd0 || early) begin
                bad++;
                $display("FAIL stall_hold[%0d]: done=%b busy=%b result=%h rd=%0d, required 0 1 %h %0d",
                         k, done, busy, result, rd_adr_out, r0, rd0);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== want || rd_adr_out !== 5'd17) begin
            bad++;
            $display("FAIL stall_release: done=%b busy=%b result=%h rd=%0d, required 1 0 %h 17",
                     done, busy, result, rd_adr_out, want);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_one_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          mlat;
        logic        ba;
        logic        bd;
        bit          seen;
        op = 3'd3; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; rd_adr_in = 5'd21; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_adr_out !== 5'd0) begin
            bad++;
            $display("FAIL reset_midop: busy=%b done=%b result=%h rd=%0d, required all zero",
                     busy, done, result, rd_adr_out);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (LAT_FULL) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_quiet: done/busy observed=1, required 0");
        end
        m_valid = 0;
        model_issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, mlat);
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, res, rdo, lat, ba, bd);
        total++;
        if (lat != mlat || res !== ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)) begin
            bad++;
            $display("FAIL reset_reissue: lat %0d res %h, required lat %0d res %h",
                     lat, res, mlat, ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          mlat;
        logic        ba;
        logic        bd;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed($urandom_range(0, 40)) - 20);
                         b = 32'($signed($urandom_range(0, 40)) - 20); end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: ;  // reuse previous operands so paired ops can hit
                default: begin a = $urandom; b = 32'($urandom_range(1, 9)); end
            endcase
            model_issue(o, a, b, mlat);
            issue(o, a, b, rd, res, rdo, lat, ba, bd);
            total++;
            if (res !== ref_result(o, a, b) || rdo !== rd) begin
                bad++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h rd %0d, required %h rd %0d",
                         i, o, a, b, res, rdo, ref_result(o, a, b), rd);
            end
            total++;
            if (lat != mlat || ba !== 1'b1 || bd !== 1'b0) begin
                bad++;
                $display("FAIL rand_timing[%0d] op=%0d: lat %0d busy_acc %b busy_done %b, required lat %0d 1 0",
                         i, o, lat, ba, bd, mlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_kill();
        test_stall();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
